// File: rtl/bch_err_locate.sv
// rtl/bch_err_locate.sv - BCH error locator: Chien sums to per-bit error flags, correction and per-frame error count
module bch_err_locate #(
  // Code parameter set packed as {M[31:24], T[23:16], K[15:0]}.
  parameter logic [31:0] P    = 32'h0402_001F,
  parameter int          BITS = 1,
  localparam int M         = int'(P[31:24]),
  localparam int T         = int'(P[23:16]),
  localparam int K         = int'(P[15:0]),
  localparam int CYCLES    = (K + BITS - 1) / BITS,
  localparam int LAST_BITS = K - (CYCLES - 1) * BITS,
  localparam int CW        = $clog2(K + 1),
  localparam int DW        = $clog2(T + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DW-1:0]             deg,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic                      in_valid,
  input  logic [(T+1)*M*BITS-1:0]   chien,
  input  logic [BITS-1:0]           data_in,
  output logic [BITS-1:0]           data_out,
  output logic [BITS-1:0]           err,
  output logic                      out_valid,
  output logic                      out_first,
  output logic                      out_last,
  output logic [CW-1:0]             err_count,
  output logic                      done,
  output logic                      uncorrectable
);

  localparam logic [31:0] MAXC = 32'((1 << CW) - 1);

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [DW-1:0]   deg_q, deg_n;
  logic [CW-1:0]   count_n;
  logic            unc_n;
  logic [BITS-1:0] raw_err;
  logic [BITS-1:0] beat_err;
  logic [31:0]     pop;

  // The running count never wraps; it sticks at its all-ones value.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] base, input logic [31:0] inc);
    logic [31:0] s;
    s = 32'(base) + inc;
    return (s > MAXC) ? MAXC[CW-1:0] : s[CW-1:0];
  endfunction

  // A bit position is in error when the XOR of its Chien terms is zero.
  always_comb begin
    raw_err = '0;
    for (int b = 0; b < BITS; b++) begin
      logic [M-1:0] sum;
      sum = '0;
      for (int i = 0; i <= T; i++) begin
        sum = sum ^ chien[(b*(T+1)+i)*M +: M];
      end
      raw_err[b] = (sum == '0);
    end
  end

  // Qualify flags by valid and drop padding bits of the final beat, then count them.
  always_comb begin
    beat_err = '0;
    pop      = '0;
    for (int b = 0; b < BITS; b++) begin
      beat_err[b] = in_valid & raw_err[b] & ~(in_last & (b >= LAST_BITS));
      pop         = pop + 32'(beat_err[b]);
    end
  end

  // One-cycle beat pipeline: corrected data, flags and delayed strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out  <= '0;
      err       <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      data_out  <= in_valid ? (data_in ^ beat_err) : '0;
      err       <= beat_err;
      out_valid <= in_valid;
      out_first <= in_valid & in_first;
      out_last  <= in_valid & in_last;
    end
  end

  // Frame FSM state and count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      deg_q         <= '0;
      err_count     <= '0;
      uncorrectable <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      deg_q         <= deg_n;
      err_count     <= count_n;
      uncorrectable <= unc_n;
    end
  end

  // Next-state logic; a first beat always (re)starts a frame, even from REPORT or RUN.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    deg_n   = deg_q;
    count_n = err_count;
    unc_n   = uncorrectable;
    if (in_valid && in_first) begin
      cnt_n   = sat_add('0, pop);
      deg_n   = deg;
      count_n = '0;
      unc_n   = 1'b0;
      if (in_last) begin
        state_n = REPORT;
        count_n = cnt_n;
        unc_n   = (32'(cnt_n) != 32'(deg));
      end else begin
        state_n = RUN;
      end
    end else if (state == RUN) begin
      if (in_valid) begin
        cnt_n = sat_add(cnt, pop);
        if (in_last) begin
          state_n = REPORT;
          count_n = cnt_n;
          unc_n   = (32'(cnt_n) != 32'(deg_q));
        end
      end
    end else if (state == REPORT) begin
      state_n = IDLE;
    end
  end

  assign done = (state == REPORT);

endmodule

// File: tb/tb_bch_err_locate.sv
// tb/tb_bch_err_locate.sv - directed self-checking bench for bch_err_locate
module tb_bch_err_locate;

  logic clk;
  logic reset_n;
  int   checks;
  int   passes;

  // Main instance: M=4 T=2 K=31 BITS=4 -> 8 beats, 3 live bits on the last beat
  logic [1:0]  deg1;
  logic        f1, l1, v1;
  logic [47:0] chien1;
  logic [3:0]  din1, dout1, err1;
  logic        ov1, of1, ol1, done1, unc1;
  logic [4:0]  cnt1;

  // Serial instance: M=4 T=2 K=5 BITS=1 -> 5 beats
  logic [1:0]  deg0;
  logic        f0, l0, v0;
  logic [11:0] chien0;
  logic [0:0]  din0, dout0, err0;
  logic        ov0, of0, ol0, done0, unc0;
  logic [2:0]  cnt0;

  // Single-beat instance: M=4 T=2 K=3 BITS=4 -> 1 beat, 3 live bits
  logic [1:0]  degs;
  logic        fs, ls, vs;
  logic [47:0] chiens;
  logic [3:0]  dins, douts, errs;
  logic        ovs, ofs, ols, dones, uncs;
  logic [1:0]  cnts;

  bch_err_locate #(.P(32'h0402_001F), .BITS(4)) u1 (
    .clk(clk), .reset_n(reset_n), .deg(deg1), .in_first(f1), .in_last(l1), .in_valid(v1),
    .chien(chien1), .data_in(din1), .data_out(dout1), .err(err1), .out_valid(ov1),
    .out_first(of1), .out_last(ol1), .err_count(cnt1), .done(done1), .uncorrectable(unc1));

  bch_err_locate #(.P(32'h0402_0005), .BITS(1)) u0 (
    .clk(clk), .reset_n(reset_n), .deg(deg0), .in_first(f0), .in_last(l0), .in_valid(v0),
    .chien(chien0), .data_in(din0), .data_out(dout0), .err(err0), .out_valid(ov0),
    .out_first(of0), .out_last(ol0), .err_count(cnt0), .done(done0), .uncorrectable(unc0));

  bch_err_locate #(.P(32'h0402_0003), .BITS(4)) us (
    .clk(clk), .reset_n(reset_n), .deg(degs), .in_first(fs), .in_last(ls), .in_valid(vs),
    .chien(chiens), .data_in(dins), .data_out(douts), .err(errs), .out_valid(ovs),
    .out_first(ofs), .out_last(ols), .err_count(cnts), .done(dones), .uncorrectable(uncs));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Random Chien terms whose XOR is zero exactly on the bits set in zm.
  function automatic logic [47:0] mk_chien(input logic [3:0] zm);
    logic [47:0] c;
    logic [3:0]  t1, t2, nz;
    c = '0;
    for (int b = 0; b < 4; b++) begin
      t1 = 4'($urandom);
      t2 = 4'($urandom);
      nz = 4'($urandom_range(15, 1));
      c[(b*3)*4 +: 4]   = t1 ^ t2 ^ (zm[b] ? 4'h0 : nz);
      c[(b*3+1)*4 +: 4] = t1;
      c[(b*3+2)*4 +: 4] = t2;
    end
    return c;
  endfunction

  task automatic beat1(input logic f, input logic l, input logic v, input logic [3:0] zm, input logic [3:0] d);
    f1 = f; l1 = l; v1 = v; chien1 = mk_chien(zm); din1 = d;
    @(posedge clk); #1;
  endtask

  task automatic beat0(input logic f, input logic l, input logic v, input logic z, input logic d);
    logic [47:0] c;
    c = mk_chien({3'b000, z});
    f0 = f; l0 = l; v0 = v; chien0 = c[11:0]; din0 = d;
    @(posedge clk); #1;
  endtask

  task automatic beat_s(input logic f, input logic l, input logic v, input logic [3:0] zm, input logic [3:0] d);
    fs = f; ls = l; vs = v; chiens = mk_chien(zm); dins = d;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    deg1 = 2'd0; deg0 = 2'd0; degs = 2'd0;
    f0 = 0; l0 = 0; v0 = 0; chien0 = '0; din0 = '0;
    fs = 0; ls = 0; vs = 0; chiens = '0; dins = '0;
    f1 = 1; l1 = 1; v1 = 1; chien1 = mk_chien(4'b1111); din1 = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dout1, err1, ov1, of1, ol1, cnt1, done1, unc1} !== 17'd0)
      $display("FAIL reset_u1: got %h want 0", {dout1, err1, ov1, of1, ol1, cnt1, done1, unc1});
    else passes++;
    checks++;
    if ({dout0, err0, ov0, of0, ol0, cnt0, done0, unc0} !== 10'd0)
      $display("FAIL reset_u0: got %h want 0", {dout0, err0, ov0, of0, ol0, cnt0, done0, unc0});
    else passes++;
    checks++;
    if ({douts, errs, ovs, ofs, ols, cnts, dones, uncs} !== 14'd0)
      $display("FAIL reset_us: got %h want 0", {douts, errs, ovs, ofs, ols, cnts, dones, uncs});
    else passes++;
    f1 = 0; l1 = 0; v1 = 0; chien1 = '0; din1 = '0;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_errors();
    logic d;
    deg0 = 2'd0;
    for (int c = 0; c < 5; c++) begin
      d = 1'($urandom);
      beat0(c == 0, c == 4, 1'b1, 1'b0, d);
      checks++;
      if ({dout0, err0, ov0, of0, ol0, done0} !== {d, 1'b0, 1'b1, (c == 0), (c == 4), (c == 4)})
        $display("FAIL zero_err beat %0d: got %b want %b", c, {dout0, err0, ov0, of0, ol0, done0},
                 {d, 1'b0, 1'b1, (c == 0), (c == 4), (c == 4)});
      else passes++;
    end
    checks++;
    if ({cnt0, unc0} !== 4'b000_0) $display("FAIL zero_err_count: got cnt=%0d unc=%b want 0/0", cnt0, unc0);
    else passes++;
    beat0(0, 0, 0, 0, 0);
  endtask

  task automatic test_two_errors();
    logic [3:0] zm [8];
    logic [3:0] d;
    zm = '{default: 4'b0000};
    zm[3] = 4'b0010;
    zm[7] = 4'b0100;
    deg1 = 2'd2;
    for (int c = 0; c < 8; c++) begin
      d = 4'($urandom);
      beat1(c == 0, c == 7, 1'b1, zm[c], d);
      checks++;
      if ({err1, dout1, ov1, of1, ol1, done1} !== {zm[c], d ^ zm[c], 1'b1, (c == 0), (c == 7), (c == 7)})
        $display("FAIL two_err beat %0d: got %h want %h", c, {err1, dout1, ov1, of1, ol1, done1},
                 {zm[c], d ^ zm[c], 1'b1, (c == 0), (c == 7), (c == 7)});
      else passes++;
    end
    checks++;
    if ({cnt1, unc1} !== {5'd2, 1'b0}) $display("FAIL two_err_count: got cnt=%0d unc=%b want 2/0", cnt1, unc1);
    else passes++;
    beat1(0, 0, 0, 4'b1111, 4'hF);
    checks++;
    if ({dout1, err1, ov1, done1, cnt1, unc1} !== {4'h0, 4'h0, 1'b0, 1'b0, 5'd2, 1'b0})
      $display("FAIL idle_after_frame: got %h want %h", {dout1, err1, ov1, done1, cnt1, unc1},
               {4'h0, 4'h0, 1'b0, 1'b0, 5'd2, 1'b0});
    else passes++;
  endtask

  task automatic test_mismatch();
    deg1 = 2'd2;
    for (int c = 0; c < 8; c++) begin
      beat1(c == 0, c == 7, 1'b1, (c == 5) ? 4'b0001 : 4'b0000, 4'($urandom));
      checks++;
      if (done1 !== (c == 7)) $display("FAIL mismatch_done beat %0d: got %b want %b", c, done1, (c == 7));
      else passes++;
    end
    checks++;
    if ({cnt1, unc1} !== {5'd1, 1'b1}) $display("FAIL mismatch_count: got cnt=%0d unc=%b want 1/1", cnt1, unc1);
    else passes++;
    beat1(0, 0, 0, 0, 0);
    beat1(0, 0, 0, 0, 0);
  endtask

  task automatic test_last_mask();
    logic [3:0] zm [8];
    logic [3:0] eexp;
    logic [3:0] d;
    zm = '{default: 4'b0000};
    zm[2] = 4'b1000;
    zm[7] = 4'b1001;
    deg1 = 2'd2;
    checks++;
    if ({cnt1, unc1} !== {5'd1, 1'b1}) $display("FAIL report_hold: got cnt=%0d unc=%b want 1/1", cnt1, unc1);
    else passes++;
    for (int c = 0; c < 8; c++) begin
      d = 4'($urandom);
      beat1(c == 0, c == 7, 1'b1, zm[c], d);
      eexp = (c == 7) ? 4'b0001 : zm[c];
      if (c == 0) begin
        checks++;
        if ({cnt1, unc1} !== 6'd0) $display("FAIL report_clear: got cnt=%0d unc=%b want 0/0", cnt1, unc1);
        else passes++;
      end
      checks++;
      if ({err1, dout1} !== {eexp, d ^ eexp})
        $display("FAIL last_mask beat %0d: got err=%b dout=%b want err=%b dout=%b", c, err1, dout1, eexp, d ^ eexp);
      else passes++;
    end
    checks++;
    if ({cnt1, unc1, done1} !== {5'd2, 1'b0, 1'b1})
      $display("FAIL last_mask_count: got cnt=%0d unc=%b done=%b want 2/0/1", cnt1, unc1, done1);
    else passes++;
    beat1(0, 0, 0, 0, 0);
  endtask

  task automatic test_deg_over_t();
    logic [3:0] zm [8];
    zm = '{default: 4'b0000};
    zm[0] = 4'b0001;
    zm[1] = 4'b0010;
    zm[4] = 4'b1000;
    deg1 = 2'd3;
    for (int c = 0; c < 8; c++) beat1(c == 0, c == 7, 1'b1, zm[c], 4'($urandom));
    checks++;
    if ({cnt1, unc1, done1} !== {5'd3, 1'b0, 1'b1})
      $display("FAIL deg_over_t: got cnt=%0d unc=%b done=%b want 3/0/1", cnt1, unc1, done1);
    else passes++;
    beat1(0, 0, 0, 0, 0);
  endtask

  task automatic test_restart();
    logic       ft [13] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic       lt [13] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    logic       vt [13] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
    logic [3:0] zt [13] = '{4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0};
    logic [3:0] eexp;
    deg1 = 2'd2;
    for (int c = 0; c < 13; c++) begin
      beat1(ft[c], lt[c], vt[c], zt[c], 4'($urandom));
      eexp = vt[c] ? zt[c] : 4'h0;
      checks++;
      if ({err1, ov1, of1, ol1, done1} !== {eexp, vt[c], ft[c], (c == 12), (c == 12)})
        $display("FAIL restart step %0d: got %b want %b", c, {err1, ov1, of1, ol1, done1},
                 {eexp, vt[c], ft[c], (c == 12), (c == 12)});
      else passes++;
    end
    checks++;
    if ({cnt1, unc1} !== {5'd2, 1'b0}) $display("FAIL restart_count: got cnt=%0d unc=%b want 2/0", cnt1, unc1);
    else passes++;
    beat1(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    deg1 = 2'd1;
    beat1(1, 0, 1, 4'b0001, 4'h5);
    beat1(0, 0, 1, 4'b0010, 4'hA);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({dout1, err1, ov1, of1, ol1, cnt1, done1, unc1} !== 17'd0)
      $display("FAIL reset_mid: got %h want 0", {dout1, err1, ov1, of1, ol1, cnt1, done1, unc1});
    else passes++;
    v1 = 0; f1 = 0; l1 = 0;
    #2;
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      beat1(c == 0, c == 7, 1'b1, (c == 5) ? 4'b0100 : 4'b0000, 4'($urandom));
      checks++;
      if (done1 !== (c == 7)) $display("FAIL reset_mid_done beat %0d: got %b want %b", c, done1, (c == 7));
      else passes++;
    end
    checks++;
    if ({cnt1, unc1} !== {5'd1, 1'b0}) $display("FAIL reset_mid_count: got cnt=%0d unc=%b want 1/0", cnt1, unc1);
    else passes++;
    beat1(0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    degs = 2'd2;
    beat_s(1, 1, 1, 4'b1011, 4'b1010);
    checks++;
    if ({errs, douts, ovs, ofs, ols, dones, cnts, uncs} !== {4'b0011, 4'b1001, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0})
      $display("FAIL single_beat_1: got %h want %h", {errs, douts, ovs, ofs, ols, dones, cnts, uncs},
               {4'b0011, 4'b1001, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0});
    else passes++;
    degs = 2'd1;
    beat_s(1, 1, 1, 4'b1000, 4'b0110);
    checks++;
    if ({errs, douts, ofs, ols, dones, cnts, uncs} !== {4'b0000, 4'b0110, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1})
      $display("FAIL single_beat_2: got %h want %h", {errs, douts, ofs, ols, dones, cnts, uncs},
               {4'b0000, 4'b0110, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1});
    else passes++;
    beat_s(0, 0, 0, 0, 0);
    checks++;
    if ({dones, ovs, cnts, uncs} !== {1'b0, 1'b0, 2'd0, 1'b1})
      $display("FAIL single_beat_idle: got %b want %b", {dones, ovs, cnts, uncs}, {1'b0, 1'b0, 2'd0, 1'b1});
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_zero_errors();
    test_two_errors();
    test_mismatch();
    test_last_mask();
    test_deg_over_t();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
